// File: rtl/renderer_pkg.sv
// Shared types for the renderer coordinate generator.
//   coord_cfg_t   : one rectangle (start inclusive, end exclusive) in raster space
//   coord_state_e : generator FSM states
//   DEF_HW/DEF_VW : default coordinate widths
package renderer_pkg;

  localparam int DEF_HW = 11;
  localparam int DEF_VW = 10;

  typedef struct packed {
    logic [DEF_HW-1:0] start_x;
    logic [DEF_HW-1:0] end_x;
    logic [DEF_VW-1:0] start_y;
    logic [DEF_VW-1:0] end_y;
  } coord_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } coord_state_e;

endpackage

// File: rtl/renderer_lane_mask.sv
// Partial-beat lane mask for the coordinate generator.
// Bit i is set when pixel (hcount_i + i) lies left of the exclusive bound end_x_i.
// Ports:
//   hcount_i [HW-1:0]   x of lane 0
//   end_x_i  [HW-1:0]   exclusive column bound
//   mask_o   [LANES-1:0] per-lane valid mask
module renderer_lane_mask #(
  parameter int HW    = 11,
  parameter int LANES = 1
) (
  input  logic [HW-1:0]    hcount_i,
  input  logic [HW-1:0]    end_x_i,
  output logic [LANES-1:0] mask_o
);

  // One extra bit so hcount + lane never wraps near the top of the x range.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_o[i] = (({1'b0, hcount_i} + (HW+1)'(i)) < {1'b0, end_x_i});
    end
  end

endmodule

// File: rtl/renderer_coord_gen.sv
// Pixel-coordinate generator: walks a configurable rectangle in raster order,
// LANES adjacent pixels per beat, over a valid/ready stream.
//
// Optional feature: define RENDERER_COORD_GEN_FRAME_CNT_EN to add
// frame_count_out[15:0], a wrapping count of eof transfers.
//
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   start, stop            frame control pulses
//   cfg_start_x/end_x      column range [start, end)
//   cfg_start_y/end_y      row range [start, end)
//   m_ready / m_valid      stream handshake
//   hcount_out, vcount_out x of lane 0, y of the beat
//   lane_mask              per-lane valid bits
//   sof, eol, eof          frame markers
//   busy                   high whenever not IDLE
//   cfg_err                one-cycle pulse on a rejected config
//
// Handshake: a beat transfers on a cycle where m_valid && m_ready. While
// m_valid is high and m_ready low every output holds; m_valid only falls
// after a transfer (or on reset).
module renderer_coord_gen
  import renderer_pkg::*;
#(
  parameter int HW         = DEF_HW,
  parameter int VW         = DEF_VW,
  parameter int LANES      = 1,
  parameter int CONTINUOUS = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             stop,
  input  logic [HW-1:0]    cfg_start_x,
  input  logic [HW-1:0]    cfg_end_x,
  input  logic [VW-1:0]    cfg_start_y,
  input  logic [VW-1:0]    cfg_end_y,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [HW-1:0]    hcount_out,
  output logic [VW-1:0]    vcount_out,
  output logic [LANES-1:0] lane_mask,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             busy,
`ifdef RENDERER_COORD_GEN_FRAME_CNT_EN
  output logic [15:0]      frame_count_out,
`endif
  output logic             cfg_err
);

  coord_state_e state_q, state_d;

  // Shadow config: only reloaded at frame boundaries.
  logic [HW-1:0] sx_q, sx_d, ex_q, ex_d;
  logic [VW-1:0] sy_q, sy_d, ey_q, ey_d;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          err_q, err_d;
  logic          stop_pend_q, stop_pend_d;

  logic [HW:0]      h_next;
  logic             row_end;
  logic             last_row;
  logic             xfer;
  logic             cfg_ok;
  logic [LANES-1:0] mask_w;

  assign h_next   = {1'b0, h_q} + (HW+1)'(LANES);
  assign row_end  = (h_next >= {1'b0, ex_q});
  assign last_row = (v_q == (ey_q - VW'(1)));
  assign xfer     = valid_q & m_ready;
  assign cfg_ok   = (cfg_end_x > cfg_start_x) && (cfg_end_y > cfg_start_y);

  renderer_lane_mask #(
    .HW   (HW),
    .LANES(LANES)
  ) u_lane_mask (
    .hcount_i(h_q),
    .end_x_i (ex_q),
    .mask_o  (mask_w)
  );

  always_comb begin
    state_d     = state_q;
    sx_d        = sx_q;
    ex_d        = ex_q;
    sy_d        = sy_q;
    ey_d        = ey_q;
    h_d         = h_q;
    v_d         = v_q;
    valid_d     = valid_q;
    sof_d       = sof_q;
    err_d       = 1'b0;
    stop_pend_d = stop_pend_q | stop;

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          if (cfg_ok) begin
            sx_d    = cfg_start_x;
            ex_d    = cfg_end_x;
            sy_d    = cfg_start_y;
            ey_d    = cfg_end_y;
            h_d     = cfg_start_x;
            v_d     = cfg_start_y;
            valid_d = 1'b1;
            sof_d   = 1'b1;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (xfer) begin
          sof_d = 1'b0;
          if (row_end) begin
            h_d = sx_q;
            v_d = v_q + VW'(1);
            if (last_row) begin
              // A stop arriving on the eof cycle itself also ends the run.
              if ((CONTINUOUS != 0) && !(stop_pend_q || stop)) begin
                if (cfg_ok) begin
                  sx_d  = cfg_start_x;
                  ex_d  = cfg_end_x;
                  sy_d  = cfg_start_y;
                  ey_d  = cfg_end_y;
                  h_d   = cfg_start_x;
                  v_d   = cfg_start_y;
                  sof_d = 1'b1;
                end else begin
                  err_d       = 1'b1;
                  valid_d     = 1'b0;
                  stop_pend_d = 1'b0;
                  state_d     = IDLE;
                end
              end else begin
                valid_d = 1'b0;
                state_d = LAST;
              end
            end
          end else begin
            h_d = h_next[HW-1:0];
          end
        end
      end

      LAST: begin
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        valid_d     = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      sx_q        <= '0;
      ex_q        <= '0;
      sy_q        <= '0;
      ey_q        <= '0;
      h_q         <= '0;
      v_q         <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sx_q        <= sx_d;
      ex_q        <= ex_d;
      sy_q        <= sy_d;
      ey_q        <= ey_d;
      h_q         <= h_d;
      v_q         <= v_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
    end
  end

`ifdef RENDERER_COORD_GEN_FRAME_CNT_EN
  logic [15:0] fc_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fc_q <= '0;
    end else if (xfer && row_end && last_row) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_count_out = fc_q;
`endif

  // Flags derive only from registers, so they hold while stalled; they are
  // gated by valid so an idle generator shows all zeros.
  assign m_valid    = valid_q;
  assign hcount_out = h_q;
  assign vcount_out = v_q;
  assign lane_mask  = valid_q ? mask_w : '0;
  assign sof        = sof_q;
  assign eol        = valid_q & row_end;
  assign eof        = valid_q & row_end & last_row;
  assign busy       = (state_q != IDLE);
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_renderer_coord_gen.sv
// Directed bench for renderer_coord_gen. Two instances share the config,
// stop and ready inputs: dut_a (LANES=4, single-frame) and dut_b (LANES=1,
// continuous). Inputs change and outputs are sampled on the falling edge.
module tb_renderer_coord_gen;

  typedef struct {
    int h;
    int v;
    int mask;
    bit sof;
    bit eol;
    bit eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] cfg_start_x = '0;
  logic [10:0] cfg_end_x = '0;
  logic [9:0]  cfg_start_y = '0;
  logic [9:0]  cfg_end_y = '0;
  logic        m_ready = 1'b0;

  logic        a_valid, a_sof, a_eol, a_eof, a_busy, a_err;
  logic [10:0] a_h;
  logic [9:0]  a_v;
  logic [3:0]  a_mask;
  logic        b_valid, b_sof, b_eol, b_eof, b_busy, b_err;
  logic [10:0] b_h;
  logic [9:0]  b_v;
  logic [0:0]  b_mask;
`ifdef RENDERER_COORD_GEN_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  renderer_coord_gen #(.HW(11), .VW(10), .LANES(4), .CONTINUOUS(0)) dut_a (
    .aclk(clk), .aresetn(rst_n), .start(start_a), .stop(stop),
    .cfg_start_x(cfg_start_x), .cfg_end_x(cfg_end_x),
    .cfg_start_y(cfg_start_y), .cfg_end_y(cfg_end_y),
    .m_ready(m_ready), .m_valid(a_valid), .hcount_out(a_h), .vcount_out(a_v),
    .lane_mask(a_mask), .sof(a_sof), .eol(a_eol), .eof(a_eof), .busy(a_busy),
`ifdef RENDERER_COORD_GEN_FRAME_CNT_EN
    .frame_count_out(a_fc),
`endif
    .cfg_err(a_err)
  );

  renderer_coord_gen #(.HW(11), .VW(10), .LANES(1), .CONTINUOUS(1)) dut_b (
    .aclk(clk), .aresetn(rst_n), .start(start_b), .stop(stop),
    .cfg_start_x(cfg_start_x), .cfg_end_x(cfg_end_x),
    .cfg_start_y(cfg_start_y), .cfg_end_y(cfg_end_y),
    .m_ready(m_ready), .m_valid(b_valid), .hcount_out(b_h), .vcount_out(b_v),
    .lane_mask(b_mask), .sof(b_sof), .eol(b_eol), .eof(b_eof), .busy(b_busy),
`ifdef RENDERER_COORD_GEN_FRAME_CNT_EN
    .frame_count_out(b_fc),
`endif
    .cfg_err(b_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat_a(input string tag, input beat_t e);
    chk({tag, ".valid"}, int'(a_valid), 1);
    chk({tag, ".h"}, int'(a_h), e.h);
    chk({tag, ".v"}, int'(a_v), e.v);
    chk({tag, ".mask"}, int'(a_mask), e.mask);
    chk({tag, ".sof"}, int'(a_sof), int'(e.sof));
    chk({tag, ".eol"}, int'(a_eol), int'(e.eol));
    chk({tag, ".eof"}, int'(a_eof), int'(e.eof));
  endtask

  task automatic chk_beat_b(input string tag, input beat_t e);
    chk({tag, ".valid"}, int'(b_valid), 1);
    chk({tag, ".h"}, int'(b_h), e.h);
    chk({tag, ".v"}, int'(b_v), e.v);
    chk({tag, ".mask"}, int'(b_mask), e.mask);
    chk({tag, ".sof"}, int'(b_sof), int'(e.sof));
    chk({tag, ".eol"}, int'(b_eol), int'(e.eol));
    chk({tag, ".eof"}, int'(b_eof), int'(e.eof));
  endtask

  task automatic set_cfg(input int sx, input int ex, input int sy, input int ey);
    cfg_start_x = 11'(sx);
    cfg_end_x   = 11'(ex);
    cfg_start_y = 10'(sy);
    cfg_end_y   = 10'(ey);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t vec1[4];
    beat_t vec2[2];
    beat_t vec4[6];
    beat_t single;
    logic [24:0] held;
    logic [20:0] e;
    bit          have_hold;
    bit          first_beat;
    int          n_xfer;

    // x 0..8, y 0..2, 4 lanes: two beats per row, mask always full
    vec1[0] = '{h:0, v:0, mask:4'hF, sof:1, eol:0, eof:0};
    vec1[1] = '{h:4, v:0, mask:4'hF, sof:0, eol:1, eof:0};
    vec1[2] = '{h:0, v:1, mask:4'hF, sof:0, eol:0, eof:0};
    vec1[3] = '{h:4, v:1, mask:4'hF, sof:0, eol:1, eof:1};
    // x 3..10 (width 7), y 5..6: second beat covers 7,8,9 only
    vec2[0] = '{h:3, v:5, mask:4'hF, sof:1, eol:0, eof:0};
    vec2[1] = '{h:7, v:5, mask:4'h7, sof:0, eol:1, eof:1};
    // continuous: frame 1 is 2 wide, frame 2 picks up end_x=4 with no bubble
    vec4[0] = '{h:0, v:0, mask:1, sof:1, eol:0, eof:0};
    vec4[1] = '{h:1, v:0, mask:1, sof:0, eol:1, eof:1};
    vec4[2] = '{h:0, v:0, mask:1, sof:1, eol:0, eof:0};
    vec4[3] = '{h:1, v:0, mask:1, sof:0, eol:0, eof:0};
    vec4[4] = '{h:2, v:0, mask:1, sof:0, eol:0, eof:0};
    vec4[5] = '{h:3, v:0, mask:1, sof:0, eol:1, eof:1};
    // x 5..7, y 2..3: single beat, two live lanes
    single  = '{h:5, v:2, mask:4'h3, sof:1, eol:1, eof:1};

    // ---- reset state
    tick();
    chk("rst.a_valid", int'(a_valid), 0);
    chk("rst.a_busy", int'(a_busy), 0);
    chk("rst.a_flags", int'({a_sof, a_eol, a_eof, a_err}), 0);
    chk("rst.a_coord", int'({a_h, a_v, a_mask}), 0);
    chk("rst.b_valid", int'(b_valid), 0);
    chk("rst.b_busy", int'(b_busy), 0);
    rst_n = 1'b1;
    tick();
    chk("idle.a_busy", int'(a_busy), 0);

    // ---- 8x2 region, LANES=4, single frame
    set_cfg(0, 8, 0, 2);
    m_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_beat_a($sformatf("s1.beat%0d", i), vec1[i]);
      tick();
    end
    chk("s1.end_valid", int'(a_valid), 0);
    chk("s1.last_busy", int'(a_busy), 1);
    tick();
    chk("s1.idle_busy", int'(a_busy), 0);
    chk("s1.idle_valid", int'(a_valid), 0);

    // ---- partial last beat
    set_cfg(3, 10, 5, 6);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_beat_a($sformatf("s2.beat%0d", i), vec2[i]);
      tick();
    end
    chk("s2.end_valid", int'(a_valid), 0);
    tick();
    chk("s2.idle_busy", int'(a_busy), 0);

    // ---- rejected config (empty row range)
    set_cfg(0, 8, 3, 3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("err.pulse", int'(a_err), 1);
    chk("err.valid", int'(a_valid), 0);
    chk("err.busy", int'(a_busy), 0);
    tick();
    chk("err.pulse_end", int'(a_err), 0);
    chk("err.valid_after", int'(a_valid), 0);

    // ---- stall pattern on dut_b: 4x2, ready toggles, stop pending from the start
    set_cfg(0, 4, 0, 2);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back({10'(y), 11'(x)});
    m_ready = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    stop = 1'b1;
    have_hold = 1'b0;
    first_beat = 1'b1;
    n_xfer = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (have_hold)
        chk("stall.hold", int'({b_valid, b_sof, b_eol, b_eof, b_v, b_h}), int'(held));
      m_ready = ~m_ready;
      have_hold = b_valid && !m_ready;
      held = {b_valid, b_sof, b_eol, b_eof, b_v, b_h};
      if (b_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("stall.extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("stall.h", int'(b_h), int'(e[10:0]));
          chk("stall.v", int'(b_v), int'(e[20:11]));
          chk("stall.sof", int'(b_sof), int'(first_beat));
          chk("stall.eol", int'(b_eol), int'(e[10:0] == 11'd3));
          chk("stall.eof", int'(b_eof), int'(e == {10'd1, 11'd3}));
          first_beat = 1'b0;
        end
        n_xfer++;
      end
      tick();
      stop = 1'b0;
    end
    chk("stall.xfers", n_xfer, 8);
    chk("stall.left", exp_q.size(), 0);
    chk("stall.end_valid", int'(b_valid), 0);
    chk("stall.end_busy", int'(b_busy), 0);

    // ---- continuous restart with mid-frame config change, then stop
    set_cfg(0, 2, 0, 1);
    m_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_beat_b($sformatf("cont.beat%0d", i), vec4[i]);
      if (i == 0) cfg_end_x = 11'd4;
      stop = (i == 3);
      tick();
    end
    stop = 1'b0;
    chk("cont.end_valid", int'(b_valid), 0);
    chk("cont.last_busy", int'(b_busy), 1);
    tick();
    chk("cont.idle_busy", int'(b_busy), 0);
    chk("cont.idle_valid", int'(b_valid), 0);

    // ---- async reset while a beat is stalled
    set_cfg(0, 8, 0, 2);
    m_ready = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("arst.pre_valid", int'(a_valid), 1);
    chk("arst.pre_sof", int'(a_sof), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", int'(a_valid), 0);
    chk("arst.flags", int'({a_sof, a_eol, a_eof}), 0);
    chk("arst.busy", int'(a_busy), 0);
    chk("arst.coord", int'({a_h, a_v, a_mask}), 0);
`ifdef RENDERER_COORD_GEN_FRAME_CNT_EN
    chk("arst.fc", int'(a_fc), 0);
`endif
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();

    // ---- three single-beat frames
    set_cfg(5, 7, 2, 3);
    for (int f = 0; f < 3; f++) begin
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk_beat_a($sformatf("one.f%0d", f), single);
      tick();
      chk("one.end_valid", int'(a_valid), 0);
      tick();
      chk("one.idle_busy", int'(a_busy), 0);
    end
`ifdef RENDERER_COORD_GEN_FRAME_CNT_EN
    chk("fc.three", int'(a_fc), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/renderer_coord_gen.md
Name: renderer_coord_gen

Overview:
- Parametrised next-generation pixel-coordinate generator for the renderer.
- Walks a run-time-configurable rectangle in raster order and emits LANES horizontally adjacent pixels per beat over a valid/ready handshake.
- Provides start-of-frame, end-of-line and end-of-frame markers and a partial-beat lane mask.
- Sits between the frame controller (start/stop, region config) and the per-pixel shading pipeline.

Parameters:
- HW, 11, width of x coordinate and x config ports.
- VW, 10, width of y coordinate and y config ports.
- LANES, 1, pixels per beat; power of two, 1..8.
- CONTINUOUS, 1, 1 = restart the next frame automatically after eof; 0 = stop after one frame until the next start.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a frame when idle.
- stop  in  1  pulse; finish current frame, then idle.
- cfg_start_x  in  HW  first column, inclusive.
- cfg_end_x  in  HW  column bound, exclusive.
- cfg_start_y  in  VW  first row, inclusive.
- cfg_end_y  in  VW  row bound, exclusive.
- m_ready  in  1  downstream accept.
- m_valid  out  1  beat valid.
- hcount_out  out  HW  x of lane 0.
- vcount_out  out  VW  y of the beat.
- lane_mask  out  LANES  bit i set when pixel hcount_out+i < end_x.
- sof  out  1  first beat of frame.
- eol  out  1  last beat of row.
- eof  out  1  last beat of frame.
- busy  out  1  state != IDLE.
- cfg_err  out  1  one-cycle pulse on a rejected config.

Behaviour:
- Reset (async assert, sync release): state IDLE; m_valid, sof, eol, eof, busy, cfg_err = 0; hcount_out, vcount_out, lane_mask = 0.
- States: IDLE, RUN, LAST.
- IDLE: on start, sample the cfg_* ports into shadow registers.
  - If end_x <= start_x or end_y <= start_y: pulse cfg_err the next cycle and stay IDLE.
  - Otherwise, the next cycle, enter RUN with hcount_out=start_x, vcount_out=start_y, m_valid=1, sof=1.
- Latency start -> first m_valid: exactly 1 cycle.
- Handshake:
  - A beat transfers when m_valid & m_ready.
  - While m_valid=1 and m_ready=0, all outputs hold stable.
  - m_valid never drops without a transfer, except by reset.
- Advance on transfer:
  - If hcount_out+LANES >= end_x: hcount_out <= start_x; vcount_out <= vcount_out+1.
  - Otherwise: hcount_out <= hcount_out+LANES.
  - Arithmetic is in HW+1 bits; no silent wrap.
- Flags:
  - eol = (hcount_out+LANES >= end_x).
  - eof = eol & (vcount_out == end_y-1).
  - sof is high only on the first beat and clears after its transfer.
  - lane_mask is all ones except on an eol beat with (end_x-start_x) mod LANES != 0.
- On the eof transfer:
  - If CONTINUOUS=1 and no stop is pending: re-sample cfg_* and restart with no bubble (next beat has sof=1).
  - If the re-sampled config is invalid: pulse cfg_err and go to IDLE.
  - Otherwise (CONTINUOUS=0 or stop pending): go to IDLE, m_valid=0.
- stop: latched as pending in RUN; cleared on entry to IDLE. stop in IDLE is ignored.
- start while busy: ignored.
- cfg_* changes mid-frame: no effect until the next frame boundary.
- Single-beat frame (1 row, width <= LANES): the beat carries sof=eol=eof=1.
- LAST state: one cycle after the final eof transfer, used to deassert busy. busy = 0 only in IDLE.

Optional Feature:
- Macro: RENDERER_COORD_GEN_FRAME_CNT_EN.
- Defined: adds output frame_count_out [15:0].
  - Reset to 0.
  - Increments on every eof transfer; wraps from 16'hFFFF to 0.
  - Usable by the renderer for animation time.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package renderer_pkg holds:
  - struct coord_cfg_t (start_x, end_x, start_y, end_y);
  - state enum coord_state_e {IDLE, RUN, LAST};
  - localparam default HW=11, VW=10.
- One natural sub-module: renderer_lane_mask, a combinational mask from hcount_out, end_x and LANES.
- The FSM and counters stay in the top module.

Test Plan:
- Region x 0..8, y 0..2, LANES=4, m_ready=1, CONTINUOUS=0, start -> 4 beats: (0,0) sof, (4,0) eol, (0,1), (4,1) eol eof; then IDLE, busy=0.
- Region x 3..10, LANES=4, y 5..6 -> beats (3,5) mask 1111, (7,5) mask 0111 eol eof.
- Toggle m_ready 1/0 per cycle over a 4x2 region, LANES=1 -> outputs stable while stalled; exactly 8 transfers in raster order; no duplicates or gaps.
- CONTINUOUS=1, 2x1 region; change cfg_end_x to 4 mid-frame -> frame 1 has 2 beats; frame 2 starts with no bubble, has 4 beats, sof on (0,0). Assert stop during frame 2 -> IDLE after its eof.
- start with cfg_end_y == cfg_start_y -> cfg_err one cycle later, m_valid stays 0, busy 0.
- Deassert aresetn mid-frame while m_valid=1, m_ready=0 -> m_valid and flags drop immediately (async). With RENDERER_COORD_GEN_FRAME_CNT_EN defined, frame_count_out = 0 after reset and 3 after three eof transfers.
